adffe_shift_bank: RTL and testbench

- Parametrised successor to the single-stage async-reset enable storage element in the flipFlops test set.
- DEPTH stages of WIDTH-bit flip-flops share one clock, one clock enable and one asynchronous active-high reset.
- Four modes: hold, shift, parallel load and rotate, with a valid bit tracked per stage and a registered occupancy count.
- Used as a multi-stage information-flow test subject: data, valid and reset paths are all observable at the outputs.

---
 rtl/adffe_shift_bank.sv | 138 +++++++++++++
 tb/tb_adffe_shift_bank.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adffe_shift_bank.sv
// adffe_shift_bank
//   DEPTH stages of WIDTH-bit flip-flops with a common clock, clock enable
//   and asynchronous active-high reset. Each stage carries a valid bit.
//   Supported modes are hold, shift, parallel load and rotate. A registered
//   occupancy count tracks the number of valid stages.
//
// Parameters
//   WIDTH       data bits per stage (>= 1)
//   DEPTH       number of stages (>= 2)
//   ARST_VALUE  value forced into every stage while ARST is high
//
// Ports
//   CLK       in   clock, rising edge
//   ARST      in   asynchronous active-high reset
//   EN        in   clock enable, 0 holds all state
//   MODE      in   00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE
//   D         in   data into stage 0 (SHIFT) or into all stages (LOAD)
//   VALID_IN  in   valid tag that accompanies D
//   Q         out  content of the last stage (DEPTH-1)
//   Q_VALID   out  valid bit of the last stage
//   COUNT     out  number of stages whose valid bit is set
//   FULL      out  COUNT == DEPTH
//   TAPS      out  all stages, stage i at [WIDTH*i +: WIDTH]   (optional)
//   VTAPS     out  all valid bits                               (optional)
//
// Optional feature
//   Define ADFFE_SHIFT_BANK_TAPS_EN to add the TAPS/VTAPS outputs.

module adffe_shift_bank #(
  parameter int               WIDTH      = 2,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] ARST_VALUE = '0,
  localparam int              CW         = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID_IN,
`ifdef ADFFE_SHIFT_BANK_TAPS_EN
  output logic [WIDTH*DEPTH-1:0] TAPS,
  output logic [DEPTH-1:0]       VTAPS,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [CW-1:0]    COUNT,
  output logic             FULL
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  logic [WIDTH-1:0] stage_reg  [DEPTH];
  logic [WIDTH-1:0] stage_next [DEPTH];
  logic             valid_reg  [DEPTH];
  logic             valid_next [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Upstream neighbour; for stage 0 this wraps to the last stage, which
      // is exactly the rotate source.
      localparam int PREV = (gi == 0) ? DEPTH - 1 : gi - 1;

      always_comb begin
        stage_next[gi] = stage_reg[gi];
        valid_next[gi] = valid_reg[gi];
        if (EN) begin
          case (MODE)
            MODE_SHIFT: begin
              if (gi == 0) begin
                stage_next[gi] = D;
                valid_next[gi] = VALID_IN;
              end else begin
                stage_next[gi] = stage_reg[PREV];
                valid_next[gi] = valid_reg[PREV];
              end
            end
            MODE_LOAD: begin
              stage_next[gi] = D;
              valid_next[gi] = VALID_IN;
            end
            MODE_ROTATE: begin
              stage_next[gi] = stage_reg[PREV];
              valid_next[gi] = valid_reg[PREV];
            end
            default: begin
              // MODE_HOLD: keep current contents
            end
          endcase
        end
      end

      always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
          stage_reg[gi] <= ARST_VALUE;
          valid_reg[gi] <= 1'b0;
        end else begin
          stage_reg[gi] <= stage_next[gi];
          valid_reg[gi] <= valid_next[gi];
        end
      end

`ifdef ADFFE_SHIFT_BANK_TAPS_EN
      assign TAPS[WIDTH*gi +: WIDTH] = stage_reg[gi];
      assign VTAPS[gi]               = valid_reg[gi];
`endif
    end
  endgenerate

  // Popcount of the next-state valid vector so the registered count always
  // matches the valid bits held after the same edge.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + CW'(valid_next[i]);
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign Q       = stage_reg[DEPTH-1];
  assign Q_VALID = valid_reg[DEPTH-1];
  assign COUNT   = count_reg;
  assign FULL    = (count_reg == CW'(DEPTH));

endmodule

// File: tb/tb_adffe_shift_bank.sv
// Testbench for adffe_shift_bank: directed scenarios with hand-computed
// expectations. Two instances share all inputs and differ only in ARST_VALUE.

module tb_adffe_shift_bank;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [1:0] M_HOLD   = 2'b00;
  localparam logic [1:0] M_SHIFT  = 2'b01;
  localparam logic [1:0] M_LOAD   = 2'b10;
  localparam logic [1:0] M_ROTATE = 2'b11;

  logic             CLK = 1'b0;
  logic             ARST;
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             VALID_IN;

  logic [WIDTH-1:0] q_a,  q_b;
  logic             qv_a, qv_b;
  logic [CW-1:0]    cnt_a, cnt_b;
  logic             full_a, full_b;
`ifdef ADFFE_SHIFT_BANK_TAPS_EN
  logic [WIDTH*DEPTH-1:0] taps_a, taps_b;
  logic [DEPTH-1:0]       vtaps_a, vtaps_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  adffe_shift_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ARST_VALUE(2'b00)) dut_a (
    .CLK(CLK), .ARST(ARST), .EN(EN), .MODE(MODE), .D(D), .VALID_IN(VALID_IN),
`ifdef ADFFE_SHIFT_BANK_TAPS_EN
    .TAPS(taps_a), .VTAPS(vtaps_a),
`endif
    .Q(q_a), .Q_VALID(qv_a), .COUNT(cnt_a), .FULL(full_a)
  );

  adffe_shift_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ARST_VALUE(2'b11)) dut_b (
    .CLK(CLK), .ARST(ARST), .EN(EN), .MODE(MODE), .D(D), .VALID_IN(VALID_IN),
`ifdef ADFFE_SHIFT_BANK_TAPS_EN
    .TAPS(taps_b), .VTAPS(vtaps_b),
`endif
    .Q(q_b), .Q_VALID(qv_b), .COUNT(cnt_b), .FULL(full_b)
  );

  // Advance to 1 time unit past the next rising edge and log the transaction.
  task automatic tick();
    @(posedge CLK);
    #1;
    $display("t=%0t en=%b mode=%b d=%b vi=%b | q=%b qv=%b cnt=%0d full=%b",
             $time, EN, MODE, D, VALID_IN, q_a, qv_a, cnt_a, full_a);
  endtask

  task automatic drive(input logic en, input logic [1:0] mode,
                       input logic [1:0] d, input logic vi);
    EN = en; MODE = mode; D = d; VALID_IN = vi;
  endtask

  task automatic test_reset();
    ARST = 1'b1;
    drive(1'b1, M_LOAD, 2'b11, 1'b1);
    tick();
    tick();
    n_checks++;
    if ({q_a, qv_a, cnt_a, full_a} !== {2'b00, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: got q=%b qv=%b cnt=%0d full=%b expected q=00 qv=0 cnt=0 full=0",
               q_a, qv_a, cnt_a, full_a);
    end
    n_checks++;
    if ({q_b, qv_b, cnt_b} !== {2'b11, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_b: got q=%b qv=%b cnt=%0d expected q=11 qv=0 cnt=0",
               q_b, qv_b, cnt_b);
    end
    ARST = 1'b0;
    // First edge after release operates: LOAD 11 valid
    tick();
    n_checks++;
    if ({q_a, qv_a, cnt_a, full_a} !== {2'b11, 1'b1, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL load_after_reset: got q=%b qv=%b cnt=%0d full=%b expected q=11 qv=1 cnt=4 full=1",
               q_a, qv_a, cnt_a, full_a);
    end
    // Mid-cycle pulse clears with no clock edge
    #2 ARST = 1'b1;
    #1;
    n_checks++;
    if ({q_a, qv_a, cnt_a, full_a} !== {2'b00, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_clear: got q=%b qv=%b cnt=%0d full=%b expected q=00 qv=0 cnt=0 full=0",
               q_a, qv_a, cnt_a, full_a);
    end
    // Coincident edge with LOAD is ignored while ARST is high
    tick();
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {2'b00, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL arst_over_edge: got q=%b qv=%b cnt=%0d expected q=00 qv=0 cnt=0",
               q_a, qv_a, cnt_a);
    end
    ARST = 1'b0;
    drive(1'b1, M_HOLD, 2'b11, 1'b1);
    tick();
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {2'b00, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL hold_after_reset: got q=%b qv=%b cnt=%0d expected q=00 qv=0 cnt=0",
               q_a, qv_a, cnt_a);
    end
  endtask

  task automatic test_shift();
    logic [1:0] din   [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    logic [1:0] exp_q [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    logic [2:0] exp_c [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       exp_v [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, M_SHIFT, din[i], 1'b1);
      tick();
      n_checks++;
      if ({q_a, qv_a, cnt_a, full_a} !== {exp_q[i], exp_v[i], exp_c[i], (exp_c[i] == 3'd4)}) begin
        n_fail++;
        $display("FAIL shift_%0d: got q=%b qv=%b cnt=%0d full=%b expected q=%b qv=%b cnt=%0d full=%b",
                 i, q_a, qv_a, cnt_a, full_a, exp_q[i], exp_v[i], exp_c[i], (exp_c[i] == 3'd4));
      end
    end
  endtask

  task automatic test_enable();
    // Stages now (0..3): 10,01,11,10 all valid
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, M_SHIFT, 2'b11, 1'b0);
      tick();
      n_checks++;
      if ({q_a, qv_a, cnt_a} !== {2'b10, 1'b1, 3'd4}) begin
        n_fail++;
        $display("FAIL en_hold_%0d: got q=%b qv=%b cnt=%0d expected q=10 qv=1 cnt=4",
                 i, q_a, qv_a, cnt_a);
      end
    end
    drive(1'b1, M_HOLD, 2'b00, 1'b0);
    tick();
    n_checks++;
    if ({q_a, cnt_a} !== {2'b10, 3'd4}) begin
      n_fail++;
      $display("FAIL mode_hold: got q=%b cnt=%0d expected q=10 cnt=4", q_a, cnt_a);
    end
    // Resume: stages 11,10,01,11 valid 0,1,1,1
    drive(1'b1, M_SHIFT, 2'b11, 1'b0);
    tick();
    n_checks++;
    if ({q_a, qv_a, cnt_a, full_a} !== {2'b11, 1'b1, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL en_resume: got q=%b qv=%b cnt=%0d full=%b expected q=11 qv=1 cnt=3 full=0",
               q_a, qv_a, cnt_a, full_a);
    end
  endtask

  task automatic test_load_rotate();
    logic [1:0] exp_q [4] = '{2'b10, 2'b10, 2'b01, 2'b10};
    logic       exp_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    drive(1'b1, M_LOAD, 2'b10, 1'b1);
    tick();
    n_checks++;
    if ({q_a, qv_a, cnt_a, full_a} !== {2'b10, 1'b1, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL load: got q=%b qv=%b cnt=%0d full=%b expected q=10 qv=1 cnt=4 full=1",
               q_a, qv_a, cnt_a, full_a);
    end
    // Stages 01,10,10,10 valid 0,1,1,1
    drive(1'b1, M_SHIFT, 2'b01, 1'b0);
    tick();
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {2'b10, 1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL shift_invalid: got q=%b qv=%b cnt=%0d expected q=10 qv=1 cnt=3",
               q_a, qv_a, cnt_a);
    end
    // D and VALID_IN must be ignored while rotating
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, M_ROTATE, 2'b11, 1'b1);
      tick();
      n_checks++;
      if ({q_a, qv_a, cnt_a} !== {exp_q[i], exp_v[i], 3'd3}) begin
        n_fail++;
        $display("FAIL rotate_%0d: got q=%b qv=%b cnt=%0d expected q=%b qv=%b cnt=3",
                 i, q_a, qv_a, cnt_a, exp_q[i], exp_v[i]);
      end
    end
    // Pattern restored: shifting out shows stage2 then stage1 (both 10 valid)
    drive(1'b1, M_SHIFT, 2'b00, 1'b0);
    tick();
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {2'b10, 1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL rotate_restore: got q=%b qv=%b cnt=%0d expected q=10 qv=1 cnt=2",
               q_a, qv_a, cnt_a);
    end
  endtask

  task automatic test_arst_value();
    drive(1'b1, M_SHIFT, 2'b01, 1'b1);
    tick();
    #2 ARST = 1'b1;
    #1;
    n_checks++;
    if ({q_b, qv_b, cnt_b, full_b} !== {2'b11, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL arst_value_b: got q=%b qv=%b cnt=%0d full=%b expected q=11 qv=0 cnt=0 full=0",
               q_b, qv_b, cnt_b, full_b);
    end
    n_checks++;
    if ({q_a, cnt_a} !== {2'b00, 3'd0}) begin
      n_fail++;
      $display("FAIL arst_value_a: got q=%b cnt=%0d expected q=00 cnt=0", q_a, cnt_a);
    end
    #1 ARST = 1'b0;
    drive(1'b1, M_SHIFT, 2'b01, 1'b1);
    tick();
    n_checks++;
    if ({q_b, qv_b, cnt_b} !== {2'b11, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL release_shift: got q=%b qv=%b cnt=%0d expected q=11 qv=0 cnt=1",
               q_b, qv_b, cnt_b);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, M_SHIFT, 2'b00, 1'b0);
      tick();
    end
    n_checks++;
    if ({q_b, qv_b, cnt_b} !== {2'b01, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL release_reach_q: got q=%b qv=%b cnt=%0d expected q=01 qv=1 cnt=1",
               q_b, qv_b, cnt_b);
    end
  endtask

`ifdef ADFFE_SHIFT_BANK_TAPS_EN
  task automatic test_taps();
    #2 ARST = 1'b1;
    #2 ARST = 1'b0;
    drive(1'b1, M_SHIFT, 2'b10, 1'b1);
    tick();
    drive(1'b1, M_SHIFT, 2'b01, 1'b1);
    tick();
    n_checks++;
    if ({taps_a, vtaps_a} !== {8'b0000_1001, 4'b0011}) begin
      n_fail++;
      $display("FAIL taps: got taps=%b vtaps=%b expected taps=00001001 vtaps=0011",
               taps_a, vtaps_a);
    end
    n_checks++;
    if (taps_b !== 8'b1111_1001) begin
      n_fail++;
      $display("FAIL taps_b: got taps=%b expected taps=11111001", taps_b);
    end
  endtask
`endif

  initial begin
    drive(1'b0, M_HOLD, 2'b00, 1'b0);
    ARST = 1'b1;
    test_reset();
    test_shift();
    test_enable();
    test_load_rotate();
    test_arst_value();
`ifdef ADFFE_SHIFT_BANK_TAPS_EN
    test_taps();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
